// File: rtl/sha_msg_feeder_pkg.sv
// Shared types and limits for the sha_engine request path: algorithm modes, message-size limits
// and the feeder's FSM state encoding.
package sha_msg_feeder_pkg;

  typedef enum logic [1:0] {
    sha1   = 2'd0,
    sha256 = 2'd1,
    sha512 = 2'd2
  } mode_t;

  localparam int unsigned MSG_W     = 1024;
  // Largest message that still fits in one padded block of the algorithm.
  localparam int unsigned MAX512_B  = 55;
  localparam int unsigned MAX1024_B = 111;

  typedef enum logic [2:0] {
    StCollect,
    StDrop,
    StIssue,
    StWaitBusy,
    StWaitDone
  } feeder_state_e;

  function automatic logic [7:0] max_len(input mode_t mode);
    return (mode == sha512) ? 8'(MAX1024_B) : 8'(MAX512_B);
  endfunction

endpackage

// File: rtl/sha_msg_feeder.sv
// Collects one byte-stream message, right-aligns it and issues a single request to sha_engine,
// then waits for the engine to finish before accepting the next message.
module sha_msg_feeder
  import sha_msg_feeder_pkg::*;
#(
  parameter int unsigned MsgW = MSG_W
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  mode_t           cfg_mode_i,
  input  logic            s_valid_i,
  output logic            s_ready_o,
  input  logic [7:0]      s_data_i,
  input  logic            s_last_i,
  output logic            eng_valid_o,
  output mode_t           eng_mode_o,
  output logic [MsgW-1:0] eng_msg_o,
  output logic [7:0]      eng_len_o,
  input  logic            eng_ready_i,
  output logic            busy_o,
  output logic            err_ovf_o
);

  feeder_state_e   state_q;
  logic [MsgW-1:0] msg_q;
  logic [7:0]      len_q;
  mode_t           mode_q;
  logic            s_ready_q;
  logic            eng_valid_q;
  logic            busy_q;
  logic            err_ovf_q;
  logic [1:0]      wait_cnt_q;

  logic            accept;
  mode_t           msg_mode;
  logic [7:0]      len_inc;
  logic [7:0]      limit;

  // The first byte of a message decides the mode, so its limit must come from cfg_mode_i.
  assign accept   = s_valid_i & s_ready_q;
  assign msg_mode = (len_q == 8'd0) ? cfg_mode_i : mode_q;
  assign len_inc  = len_q + 8'd1;
  assign limit    = max_len(msg_mode);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StCollect;
      msg_q       <= '0;
      len_q       <= '0;
      mode_q      <= sha1;
      s_ready_q   <= 1'b1;
      eng_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      err_ovf_q   <= 1'b0;
      wait_cnt_q  <= '0;
    end else begin
      eng_valid_q <= 1'b0;
      err_ovf_q   <= 1'b0;
      unique case (state_q)
        StCollect: begin
          if (accept) begin
            busy_q <= 1'b1;
            if (len_q == 8'd0) mode_q <= cfg_mode_i;
            if (len_inc > limit) begin
              // An overflowing final byte ends the drop right away.
              if (s_last_i) begin
                err_ovf_q <= 1'b1;
                msg_q     <= '0;
                len_q     <= '0;
                busy_q    <= 1'b0;
              end else begin
                state_q <= StDrop;
              end
            end else begin
              msg_q <= {msg_q[MsgW-9:0], s_data_i};
              len_q <= len_inc;
              if (s_last_i) begin
                state_q   <= StIssue;
                s_ready_q <= 1'b0;
              end
            end
          end
        end
        StDrop: begin
          if (accept && s_last_i) begin
            err_ovf_q <= 1'b1;
            msg_q     <= '0;
            len_q     <= '0;
            busy_q    <= 1'b0;
            state_q   <= StCollect;
          end
        end
        StIssue: begin
          if (eng_ready_i) begin
            eng_valid_q <= 1'b1;
            wait_cnt_q  <= '0;
            state_q     <= StWaitBusy;
          end
        end
        StWaitBusy: begin
          // An engine that never drops ready is assumed to have taken the request.
          if (!eng_ready_i || wait_cnt_q == 2'd3) begin
            state_q <= StWaitDone;
          end else begin
            wait_cnt_q <= wait_cnt_q + 2'd1;
          end
        end
        StWaitDone: begin
          if (eng_ready_i) begin
            msg_q     <= '0;
            len_q     <= '0;
            busy_q    <= 1'b0;
            s_ready_q <= 1'b1;
            state_q   <= StCollect;
          end
        end
        default: state_q <= StCollect;
      endcase
    end
  end

  assign s_ready_o   = s_ready_q;
  assign eng_valid_o = eng_valid_q;
  assign eng_mode_o  = mode_q;
  assign eng_msg_o   = msg_q;
  assign eng_len_o   = len_q;
  assign busy_o      = busy_q;
  assign err_ovf_o   = err_ovf_q;

endmodule

// File: tb/tb_sha_msg_feeder.sv
// Directed plus randomized bench for sha_msg_feeder with a simple engine model and a
// message-level reference (byte list -> right-aligned word, length, first-byte mode, limit).
module tb_sha_msg_feeder;
  import sha_msg_feeder_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  mode_t         cfg_mode = sha1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [7:0]    s_data = 8'h00;
  logic          s_last = 1'b0;
  logic          eng_valid;
  mode_t         eng_mode;
  logic [1023:0] eng_msg;
  logic [7:0]    eng_len;
  logic          eng_ready = 1'b1;
  logic          busy;
  logic          err_ovf;

  always #5 clk = ~clk;

  sha_msg_feeder #(.MsgW(1024)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .cfg_mode_i (cfg_mode),
    .s_valid_i  (s_valid),
    .s_ready_o  (s_ready),
    .s_data_i   (s_data),
    .s_last_i   (s_last),
    .eng_valid_o(eng_valid),
    .eng_mode_o (eng_mode),
    .eng_msg_o  (eng_msg),
    .eng_len_o  (eng_len),
    .eng_ready_i(eng_ready),
    .busy_o     (busy),
    .err_ovf_o  (err_ovf)
  );

  int checks = 0;
  int errors = 0;
  int vcnt = 0;
  int ocnt = 0;
  int viol = 0;
  logic [1023:0] cap_msg = '0;
  logic [7:0]    cap_len = '0;
  mode_t         cap_mode = sha1;
  bit            chk_inv = 1'b1;
  bit            eng_hang = 1'b0;
  int            eng_lat = 3;
  int            busy_left = 0;
  logic [7:0]    byte_q [128];

  // Engine model: drops ready for eng_lat cycles after each request unless hung.
  always @(posedge clk) begin
    if (eng_valid && !eng_hang) begin
      eng_ready <= 1'b0;
      busy_left <= eng_lat;
    end else if (!eng_ready) begin
      if (busy_left <= 1) eng_ready <= 1'b1;
      else busy_left <= busy_left - 1;
    end
  end

  // Observer: captures requests, counts pulses, and checks the engine-busy invariants.
  initial forever begin
    @(posedge clk);
    #1;
    if (eng_valid === 1'b1) begin
      vcnt++;
      cap_msg  = eng_msg;
      cap_len  = eng_len;
      cap_mode = eng_mode;
    end
    if (err_ovf === 1'b1) ocnt++;
    if (chk_inv && !eng_ready) begin
      if (s_ready !== 1'b0 || eng_msg !== cap_msg || eng_len !== cap_len || eng_mode !== cap_mode)
        viol++;
    end
  end

  task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs[191:0], exp[191:0]);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_s_ready"}, 1024'(s_ready), 1024'(1'b1));
    chk({tag, "_eng_valid"}, 1024'(eng_valid), 1024'(1'b0));
    chk({tag, "_eng_mode"}, 1024'(eng_mode), 1024'(sha1));
    chk({tag, "_eng_msg"}, eng_msg, '0);
    chk({tag, "_eng_len"}, 1024'(eng_len), '0);
    chk({tag, "_busy"}, 1024'(busy), '0);
    chk({tag, "_err_ovf"}, 1024'(err_ovf), '0);
  endtask

  function automatic int load_str(input string s);
    for (int i = 0; i < s.len(); i++) byte_q[i] = s[i];
    return s.len();
  endfunction

  // Message of n bytes, first byte most significant, last byte in [7:0].
  function automatic logic [1023:0] ref_msg(input int n);
    logic [1023:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[8*(n-1-i) +: 8] = byte_q[i];
    return r;
  endfunction

  task automatic send(input int from, input int to, input int n, input mode_t m, input int sw,
                      input mode_t m2);
    for (int i = from; i < to; i++) begin
      int g;
      g = 0;
      if ($urandom_range(3) == 0) begin
        s_valid = 1'b0;
        @(negedge clk);
      end
      while (!s_ready && g < 300) begin
        s_valid = 1'b0;
        @(negedge clk);
        g++;
      end
      s_valid  = 1'b1;
      s_data   = byte_q[i];
      s_last   = (i == n - 1);
      cfg_mode = (i >= sw) ? m2 : m;
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic do_msg(input string tag, input mode_t m, input int n, input int sw,
                        input mode_t m2, input int pre);
    int v0;
    int o0;
    int g;
    int lim;
    mode_t first;
    logic [1023:0] exp;
    v0    = vcnt;
    o0    = ocnt;
    first = (sw <= 0) ? m2 : m;
    lim   = (first == sha512) ? 111 : 55;
    exp   = ref_msg(n);
    send(pre, n, n, m, sw, m2);
    if (n > lim) begin
      chk({tag, "_ovf_pulse"}, 1024'(err_ovf), 1024'(1'b1));
      repeat (3) @(negedge clk);
      chk_i({tag, "_ovf_count"}, ocnt - o0, 1);
      chk_i({tag, "_ovf_no_req"}, vcnt - v0, 0);
      chk({tag, "_ovf_idle"}, 1024'({busy, s_ready}), 1024'(2'b01));
    end else begin
      chk({tag, "_hold_off"}, 1024'({busy, s_ready}), 1024'(2'b10));
      g = 0;
      while (vcnt == v0 && g < 200) begin
        @(negedge clk);
        g++;
      end
      chk_i({tag, "_req_count"}, vcnt - v0, 1);
      chk({tag, "_msg"}, cap_msg, exp);
      chk_i({tag, "_len"}, int'(cap_len), n);
      chk({tag, "_mode"}, 1024'(cap_mode), 1024'(first));
      chk_i({tag, "_no_ovf"}, ocnt - o0, 0);
      @(negedge clk);
      chk({tag, "_one_pulse"}, 1024'(eng_valid), 1024'(1'b0));
    end
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (!(s_ready && !busy) && g < 300) begin
      @(negedge clk);
      g++;
    end
  endtask

  initial begin
    int n;
    int v0;
    int lim;
    mode_t m;
    mode_t m2;

    repeat (3) @(negedge clk);
    check_reset("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset("post_rst");

    eng_lat = 4;
    n = load_str("cops queers");
    do_msg("t1", sha256, n, 99, sha256, 0);
    chk("t1_literal", cap_msg, 1024'h636F707320717565657273);

    n = load_str("cops queers");
    do_msg("t2a", sha512, n, 99, sha512, 0);
    n = load_str("hello world");
    do_msg("t2b", sha256, n, 99, sha256, 0);
    chk("t2_literal", cap_msg, 1024'h68656C6C6F20776F726C64);

    for (int i = 0; i < 56; i++) byte_q[i] = 8'($urandom);
    do_msg("t3_ovf", sha1, 56, 99, sha1, 0);
    for (int i = 0; i < 3; i++) byte_q[i] = 8'($urandom);
    do_msg("t3_next", sha1, 3, 99, sha1, 0);

    for (int i = 0; i < 112; i++) byte_q[i] = 8'($urandom);
    do_msg("t4_max", sha512, 111, 99, sha512, 0);
    do_msg("t4_ovf", sha512, 112, 99, sha512, 0);

    for (int i = 0; i < 60; i++) byte_q[i] = 8'($urandom);
    do_msg("t5_switch", sha1, 10, 3, sha512, 0);
    do_msg("t5_switch_ovf", sha1, 60, 1, sha512, 0);

    wait_idle();
    eng_hang = 1'b1;
    v0 = vcnt;
    for (int i = 0; i < 5; i++) byte_q[i] = 8'($urandom);
    do_msg("hang", sha256, 5, 99, sha256, 0);
    wait_idle();
    repeat (3) @(negedge clk);
    chk("hang_back_idle", 1024'({busy, s_ready}), 1024'(2'b01));
    chk_i("hang_single_req", vcnt - v0, 1);
    eng_hang = 1'b0;

    eng_lat = 40;
    for (int i = 0; i < 4; i++) byte_q[i] = 8'($urandom);
    do_msg("t6_pre", sha512, 4, 99, sha512, 0);
    repeat (5) @(negedge clk);
    chk("t6_in_wait", 1024'({busy, s_ready}), 1024'(2'b10));
    chk_inv = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset("t6_rst");
    @(negedge clk);
    rst_n = 1'b1;
    eng_lat = 3;
    for (int i = 0; i < 3; i++) byte_q[i] = 8'($urandom);
    send(0, 1, 3, sha256, 99, sha256);
    chk_i("t6_first_len", int'(eng_len), 1);
    chk("t6_first_msg", eng_msg, 1024'(byte_q[0]));
    do_msg("t6_after", sha256, 3, 99, sha256, 1);
    chk_inv = 1'b1;

    for (int k = 0; k < 24; k++) begin
      int sw;
      eng_lat = $urandom_range(1, 8);
      m   = mode_t'($urandom_range(2));
      m2  = mode_t'($urandom_range(2));
      sw  = $urandom_range(0, 12);
      lim = (((sw == 0) ? m2 : m) == sha512) ? 111 : 55;
      n   = $urandom_range(1, lim + 4);
      for (int i = 0; i < n; i++) byte_q[i] = 8'($urandom);
      do_msg($sformatf("rnd%0d", k), m, n, sw, m2, 0);
    end

    wait_idle();
    repeat (10) @(negedge clk);
    chk_i("engine_busy_invariants", viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
